// File: rtl/layer_pkg.sv
// layer_pkg: shared FP32 constants, ECG class encodings and argmax FSM states.
package layer_pkg;
    localparam int FP32_W = 32;
    localparam logic [7:0] FP32_EXP_MAX = 8'hFF;
    localparam int NUM_CLASSES = 4;
    localparam int CLASS_NORMAL = 0;
    localparam int CLASS_AF = 1;
    localparam int CLASS_OTHER = 2;
    localparam int CLASS_NOISY = 3;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;
endpackage

// File: rtl/fp32_relu_clamp.sv
// fp32_relu_clamp: ReLU-style clamp of one FP32 word; negatives (incl. -0) and NaNs become +0.
module fp32_relu_clamp
    import layer_pkg::*;
(
    input  logic [FP32_W-1:0] din_i,
    output logic [FP32_W-1:0] dout_o,
    output logic              is_nan_o
);
    assign is_nan_o = (din_i[30:23] == FP32_EXP_MAX) && (din_i[22:0] != 23'd0);
    assign dout_o = (din_i[31] || is_nan_o) ? '0 : din_i;
endmodule

// File: rtl/layer4_argmax.sv
// layer4_argmax: captures one frame of layer-4 FP32 scores and scans it one element
// per cycle, reporting the index and value of the largest clamped score.
module layer4_argmax
    import layer_pkg::*;
#(
    parameter int N_CLASSES = 4,
    parameter int DATA_W = 32,
    parameter int IDX_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_CLASSES*DATA_W-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_class,
    output logic [DATA_W-1:0]           out_score,
    output logic                        out_nan
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);

    argmax_state_t state_q, state_d;
    logic [N_CLASSES*DATA_W-1:0] frame_q, frame_d;
    logic [IDX_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
    logic [DATA_W-1:0] best_q, best_d, elem_raw, elem_c;
    logic nan_q, nan_d, elem_nan;

    // Single clamp shared between the accept cycle (elem0) and the scan cycles.
    assign elem_raw = (state_q == SCAN) ? frame_q[int'(cnt_q)*DATA_W +: DATA_W] : in_data[DATA_W-1:0];

    fp32_relu_clamp u_clamp (
        .din_i    (elem_raw),
        .dout_o   (elem_c),
        .is_nan_o (elem_nan)
    );

    assign in_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_class = idx_q;
    assign out_score = best_q;
    assign out_nan = nan_q;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d = cnt_q;
        best_d = best_q;
        idx_d = idx_q;
        nan_d = nan_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                frame_d = in_data;
                best_d = elem_c;
                idx_d = '0;
                nan_d = elem_nan;
                cnt_d = IDX_W'(1);
                state_d = (N_CLASSES == 1) ? DONE : SCAN;
            end
        end else if (state_q == SCAN) begin
            // Strict compare of magnitude bits keeps the lower index on ties.
            if (elem_c[30:0] > best_q[30:0]) begin
                best_d = elem_c;
                idx_d = cnt_q;
            end
            nan_d = nan_q | elem_nan;
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? DONE : SCAN;
        end else begin
            state_d = out_ready ? IDLE : DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            cnt_q <= '0;
            best_q <= '0;
            idx_q <= '0;
            nan_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q <= cnt_d;
            best_q <= best_d;
            idx_q <= idx_d;
            nan_q <= nan_d;
        end
    end
endmodule

// File: tb/tb_layer4_argmax.sv
// tb_layer4_argmax: directed and randomized checks of layer4_argmax against a behavioural argmax model.
module tb_layer4_argmax;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [N*32-1:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [1:0] out_class;
    logic [31:0] out_score;
    logic out_nan;

    int n_tests = 0;
    int n_fail = 0;

    layer4_argmax #(.N_CLASSES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score),
        .out_nan   (out_nan)
    );

    always #5 clk = ~clk;

    function automatic logic ref_isnan(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 0);
    endfunction

    function automatic logic [31:0] ref_clamp(input logic [31:0] w);
        return (w[31] || ref_isnan(w)) ? 32'h0 : w;
    endfunction

    // Reference: first index holding the maximum clamped value; NaN flag is OR of all elements.
    task automatic ref_model(input logic [N*32-1:0] d, output logic [1:0] cls, output logic [31:0] score, output logic nan);
        logic [31:0] v;
        cls = 0;
        score = ref_clamp(d[31:0]);
        nan = 1'b0;
        for (int k = 0; k < N; k++) begin
            v = ref_clamp(d[k*32 +: 32]);
            nan = nan | ref_isnan(d[k*32 +: 32]);
            if (v > score) begin
                score = v;
                cls = 2'(k);
            end
        end
    endtask

    function automatic logic [31:0] rand_elem();
        logic [31:0] w;
        case ($urandom_range(0, 7))
            0: w = 32'h80000000;
            1: w = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
            2: w = {1'($urandom), 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
            3: w = 32'h7F800000;
            4: w = 32'h0;
            5: w = {9'h07F, 23'($urandom_range(0, 3))};
            default: w = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
        return w;
    endfunction

    // Presents a frame in IDLE, waits for the accept edge, then counts edges until out_valid.
    task automatic send_frame(input logic [N*32-1:0] d, output int lat);
        @(negedge clk);
        in_data = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== 2'd0 || out_score !== 32'h0 || out_nan !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: rdy=%b vld=%b cls=%0d score=%h nan=%b, required 1 0 0 00000000 0", in_ready, out_valid, out_class, out_score, out_nan);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed(input string name, input logic [N*32-1:0] d);
        int lat;
        logic [1:0] ec;
        logic [31:0] es;
        logic en;
        ref_model(d, ec, es, en);
        send_frame(d, lat);
        n_tests++;
        if (lat !== N - 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, lat, N - 1);
        end
        n_tests++;
        if (out_class !== ec || out_score !== es || out_nan !== en || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s result: cls=%0d score=%h nan=%b rdy=%b, required cls=%0d score=%h nan=%b rdy=0", name, out_class, out_score, out_nan, in_ready, ec, es, en);
        end
        release_out();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s handoff: vld=%b rdy=%b, required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [1:0] ec;
        logic [31:0] es;
        logic en;
        logic [N*32-1:0] a = {32'h3F800000, 32'h41200000, 32'h7FC00001, 32'h40000000};
        logic [N*32-1:0] b = {32'h40A00000, 32'h3F800000, 32'h40A00001, 32'h40000000};
        ref_model(a, ec, es, en);
        send_frame(a, lat);
        @(negedge clk);
        in_data = b;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== ec || out_score !== es || out_nan !== en) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b cls=%0d score=%h nan=%b, required 1 0 %0d %h %b", i, out_valid, in_ready, out_class, out_score, out_nan, ec, es, en);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = '1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ref_model(b, ec, es, en);
        n_tests++;
        if (lat !== N - 1 || out_class !== ec || out_score !== es || out_nan !== en) begin
            n_fail++;
            $display("FAIL bp_second: lat=%0d cls=%0d score=%h nan=%b, required %0d %0d %h %b", lat, out_class, out_score, out_nan, N - 1, ec, es, en);
        end
        release_out();
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        logic [N*32-1:0] d = {32'h40400000, 32'h3F000000, 32'h40000000, 32'h7FC00000};
        @(negedge clk);
        in_data = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_class !== 2'd0 || out_score !== 32'h0 || out_nan !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: vld=%b rdy=%b cls=%0d score=%h nan=%b, required 0 1 0 00000000 0", out_valid, in_ready, out_class, out_score, out_nan);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        n_tests++;
        if (lat !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_output: out_valid seen %0d cycles, required 0", lat);
        end
        test_directed("rst_mid_next", {32'h3F800000, 32'h40E00000, 32'hC1000000, 32'h40E00000});
    endtask

    task automatic test_random();
        int lat;
        int hold;
        logic [N*32-1:0] d;
        logic [1:0] ec;
        logic [31:0] es;
        logic en;
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < N; k++) d[k*32 +: 32] = rand_elem();
            if ($urandom_range(0, 3) == 0) d[32*$urandom_range(1, N-1) +: 32] = d[31:0];
            ref_model(d, ec, es, en);
            send_frame(d, lat);
            n_tests++;
            if (lat !== N - 1 || out_class !== ec || out_score !== es || out_nan !== en) begin
                n_fail++;
                $display("FAIL rand[%0d] d=%h: lat=%0d cls=%0d score=%h nan=%b, required %0d %0d %h %b", f, d, lat, out_class, out_score, out_nan, N - 1, ec, es, en);
            end
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                n_tests++;
                if (out_valid !== 1'b1 || out_class !== ec || out_score !== es || out_nan !== en) begin
                    n_fail++;
                    $display("FAIL rand_hold[%0d]: vld=%b cls=%0d score=%h nan=%b, required 1 %0d %h %b", f, out_valid, out_class, out_score, out_nan, ec, es, en);
                end
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_out_ready: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        test_directed("basic", {32'h40400000, 32'h3F000000, 32'h40000000, 32'h3F800000});
        test_directed("tie", {32'h0, 32'h0, 32'h40000000, 32'h40000000});
        test_directed("negatives", {32'hC0400000, 32'h80000000, 32'hC0000000, 32'hBF800000});
        test_directed("nan", {32'h3F800000, 32'h3F800000, 32'h7FC00000, 32'h3F800000});
        test_directed("inf", {32'h7F800000, 32'h7F7FFFFF, 32'hFF800000, 32'h7F800000});
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
